cplx_mul_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined Q15 complex multiplier among NREQ requesters.
- Each requester presents an operand pair (a, b) with a valid/ready handshake.
- The block issues at most one product per cycle into the pipeline, tags it with the requester index, and returns the result to that requester exactly PIPE cycles later.
- Sits between DSP stages (mixers, twiddle rotators) that need occasional complex multiplies and cannot each afford a multiplier.

---
 rtl/cplx_mul_sched_pkg.sv | 30 +++
 rtl/cplx_mul_sched_if.sv | 30 +++
 rtl/cplx_mul_pipe.sv | 127 ++++++++++++
 rtl/cplx_mul_sched.sv | 110 +++++++++++
 tb/tb_cplx_mul_sched.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cplx_mul_sched_pkg.sv
// ----------------------------------------------------------------------------
// Q15Types : Q15 scalar/complex types and the reference complex multiply.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package Q15Types;

  typedef logic signed [15:0] Q15;

  typedef struct packed {
    Q15 re;
    Q15 im;
  } CplxQ15;

  // 32-bit intermediates wrap; the >>>15 result is truncated to 16 bits.
  function automatic CplxQ15 mulCplxQ15(input CplxQ15 a, input CplxQ15 b);
    logic signed [31:0] re_acc;
    logic signed [31:0] im_acc;
    CplxQ15             r;
    re_acc = 32'(a.re) * 32'(b.re) - 32'(a.im) * 32'(b.im);
    im_acc = 32'(a.re) * 32'(b.im) + 32'(a.im) * 32'(b.re);
    r.re   = Q15'(re_acc >>> 15);
    r.im   = Q15'(im_acc >>> 15);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cplx_mul_sched_if.sv
// ----------------------------------------------------------------------------
// cplx_mul_sched_if : requester operand handshake and shared result bus.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface cplx_mul_sched_if #(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]                   req_valid;
  logic [NREQ-1:0]                   req_ready;
  Q15Types::CplxQ15 [NREQ-1:0]       req_a;
  Q15Types::CplxQ15 [NREQ-1:0]       req_b;
  logic [NREQ-1:0]                   rsp_valid;
  Q15Types::CplxQ15                  rsp_c;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_c
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_c
  );

endinterface

`default_nettype wire

// File: rtl/cplx_mul_pipe.sv
// ----------------------------------------------------------------------------
// cplx_mul_pipe : PIPE-cycle Q15 complex multiplier carrying a requester tag.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cplx_mul_pipe
  import Q15Types::*;
#(
  parameter int PIPE = 3,
  parameter int TW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [TW-1:0] in_tag,
  input  CplxQ15        a,
  input  CplxQ15        b,
  output logic          out_valid,
  output logic [TW-1:0] out_tag,
  output CplxQ15        c
);

  localparam int NDLY = (PIPE >= 3) ? PIPE - 3 : PIPE;

  logic          w_tv;
  logic [TW-1:0] w_ttag;
  CplxQ15        w_tc;

  generate
    if (PIPE >= 3) begin : g_staged
      logic               r1_v;
      logic [TW-1:0]      r1_tag;
      CplxQ15             r1_a;
      CplxQ15             r1_b;
      logic               r2_v;
      logic [TW-1:0]      r2_tag;
      logic signed [31:0] r2_rr;
      logic signed [31:0] r2_ii;
      logic signed [31:0] r2_ri;
      logic signed [31:0] r2_ir;
      logic               r3_v;
      logic [TW-1:0]      r3_tag;
      CplxQ15             r3_c;

      always_ff @(posedge clk) begin
        if (rst) begin
          r1_v   <= 1'b0;
          r1_tag <= '0;
          r1_a   <= '0;
          r1_b   <= '0;
          r2_v   <= 1'b0;
          r2_tag <= '0;
          r2_rr  <= '0;
          r2_ii  <= '0;
          r2_ri  <= '0;
          r2_ir  <= '0;
          r3_v   <= 1'b0;
          r3_tag <= '0;
          r3_c   <= '0;
        end else begin
          r1_v    <= in_valid;
          r1_tag  <= in_tag;
          r1_a    <= a;
          r1_b    <= b;
          r2_v    <= r1_v;
          r2_tag  <= r1_tag;
          r2_rr   <= 32'(r1_a.re) * 32'(r1_b.re);
          r2_ii   <= 32'(r1_a.im) * 32'(r1_b.im);
          r2_ri   <= 32'(r1_a.re) * 32'(r1_b.im);
          r2_ir   <= 32'(r1_a.im) * 32'(r1_b.re);
          r3_v    <= r2_v;
          r3_tag  <= r2_tag;
          r3_c.re <= Q15'((r2_rr - r2_ii) >>> 15);
          r3_c.im <= Q15'((r2_ri + r2_ir) >>> 15);
        end
      end

      assign w_tv   = r3_v;
      assign w_ttag = r3_tag;
      assign w_tc   = r3_c;
    end else begin : g_comb
      // Shallow pipelines compute up front and only delay the result.
      assign w_tv   = in_valid;
      assign w_ttag = in_tag;
      assign w_tc   = mulCplxQ15(a, b);
    end
  endgenerate

  generate
    if (NDLY == 0) begin : g_nodly
      assign out_valid = w_tv;
      assign out_tag   = w_ttag;
      assign c         = w_tc;
    end else begin : g_dly
      logic [NDLY-1:0] r_v;
      logic [TW-1:0]   r_tag [NDLY];
      CplxQ15          r_c   [NDLY];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v <= '0;
          for (int i = 0; i < NDLY; i++) begin
            r_tag[i] <= '0;
            r_c[i]   <= '0;
          end
        end else begin
          r_v[0]   <= w_tv;
          r_tag[0] <= w_ttag;
          r_c[0]   <= w_tc;
          for (int i = 1; i < NDLY; i++) begin
            r_v[i]   <= r_v[i-1];
            r_tag[i] <= r_tag[i-1];
            r_c[i]   <= r_c[i-1];
          end
        end
      end

      assign out_valid = r_v[NDLY-1];
      assign out_tag   = r_tag[NDLY-1];
      assign c         = r_c[NDLY-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cplx_mul_sched.sv
// ----------------------------------------------------------------------------
// cplx_mul_sched : round-robin sharing of one pipelined Q15 complex multiplier.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cplx_mul_sched
  import Q15Types::*;
#(
  parameter int NREQ = 4,
  parameter int PIPE = 3,
  parameter int CW   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  cplx_mul_sched_if.slave     bus,
  output logic                busy,
  output logic [CW-1:0]       ops_cnt
);

  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FW = $clog2(PIPE + 2);

  logic [TW-1:0]   r_ptr;
  logic [CW-1:0]   r_ops;
  logic [FW-1:0]   r_inflight;
  logic [TW-1:0]   w_gnt_idx;
  logic [TW-1:0]   w_cand;
  logic            w_gnt_found;
  logic [NREQ-1:0] w_ready;
  logic [NREQ-1:0] w_rsp;
  logic            w_fire;
  logic            w_out_valid;
  logic [TW-1:0]   w_out_tag;
  CplxQ15          w_out_c;

  // Rotating first-set search starting at the priority pointer.
  always_comb begin
    int j;
    j           = 0;
    w_cand      = '0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j      = (int'(r_ptr) + k) % NREQ;
      w_cand = TW'(j);
      if (!w_gnt_found && bus.req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
    w_ready = '0;
    if (!rst && !hold && w_gnt_found) begin
      w_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign bus.req_ready = w_ready;
  assign w_fire        = |(bus.req_valid & w_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_ops      <= '0;
      r_inflight <= '0;
    end else begin
      if (w_fire) begin
        r_ptr <= (w_gnt_idx == TW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        r_ops <= r_ops + 1'b1;
      end
      // Counts the union of the pipeline valid bits without reaching inside.
      case ({w_fire, w_out_valid})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  cplx_mul_pipe #(
    .PIPE (PIPE),
    .TW   (TW)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_fire),
    .in_tag    (w_gnt_idx),
    .a         (bus.req_a[w_gnt_idx]),
    .b         (bus.req_b[w_gnt_idx]),
    .out_valid (w_out_valid),
    .out_tag   (w_out_tag),
    .c         (w_out_c)
  );

  always_comb begin
    w_rsp = '0;
    if (w_out_valid) begin
      w_rsp[w_out_tag] = 1'b1;
    end
  end

  assign bus.rsp_valid = w_rsp;
  assign bus.rsp_c     = w_out_c;
  assign busy          = (r_inflight != '0);
  assign ops_cnt       = r_ops;

endmodule

`default_nettype wire

// File: tb/tb_cplx_mul_sched.sv
// ----------------------------------------------------------------------------
// tb_cplx_mul_sched : directed self-checking bench for cplx_mul_sched.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cplx_mul_sched;
  import Q15Types::*;

  localparam int NREQ = 4;
  localparam int PIPE = 3;
  localparam int CW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          hold;
  logic          busy;
  logic [CW-1:0] ops_cnt;
  int            n_pass  = 0;
  int            n_total = 0;

  cplx_mul_sched_if #(.NREQ(NREQ)) bus ();

  cplx_mul_sched #(
    .NREQ (NREQ),
    .PIPE (PIPE),
    .CW   (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold),
    .bus     (bus),
    .busy    (busy),
    .ops_cnt (ops_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    hold          = 1'b0;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    #1;
    n_total++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", bus.req_ready); else n_pass++;
    tick();
    rst           = 1'b0;
    bus.req_valid = '0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (ops_cnt !== 32'd0) $display("FAIL reset_ops got %0d want 0", ops_cnt); else n_pass++;
    n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid got %b want 0000", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_c !== 32'h0) $display("FAIL reset_rsp_c got %h want 00000000", bus.rsp_c); else n_pass++;
  endtask

  task automatic test_single();
    bus.req_a[0]  = 32'h4000_0000;
    bus.req_b[0]  = 32'h4000_4000;
    bus.req_valid = 4'b0001;
    #1;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    n_total++; if (ops_cnt !== 32'd1) $display("FAIL single_ops got %0d want 1", ops_cnt); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else n_pass++;
    n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL single_early0 got %b want 0000", bus.rsp_valid); else n_pass++;
    tick();
    n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL single_early1 got %b want 0000", bus.rsp_valid); else n_pass++;
    tick();
    n_total++; if (bus.rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid got %b want 0001", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_c !== 32'h2000_2000) $display("FAIL single_rsp_c got %h want 20002000", bus.rsp_c); else n_pass++;
    tick();
    n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL single_rsp_off got %b want 0000", bus.rsp_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy_off got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_wrap();
    bus.req_a[0]  = 32'h8000_0000;
    bus.req_b[0]  = 32'h8000_0000;
    bus.req_valid = 4'b0001;
    #1;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL wrap_ready0 got %b want 0001", bus.req_ready); else n_pass++;
    tick();
    bus.req_a[0] = 32'h7FFF_7FFF;
    bus.req_b[0] = 32'h7FFF_8000;
    #1;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL wrap_ready1 got %b want 0001", bus.req_ready); else n_pass++;
    tick();
    bus.req_a[0] = 32'h8000_8000;
    bus.req_b[0] = 32'h8000_7FFF;
    tick();
    bus.req_valid = '0;
    n_total++; if (bus.rsp_valid !== 4'b0001) $display("FAIL wrap_rsp0_valid got %b want 0001", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_c !== 32'h8000_0000) $display("FAIL wrap_rsp0_c got %h want 80000000", bus.rsp_c); else n_pass++;
    tick();
    n_total++; if (bus.rsp_c !== 32'hFFFD_FFFF) $display("FAIL wrap_rsp1_c got %h want fffdffff", bus.rsp_c); else n_pass++;
    tick();
    n_total++; if (bus.rsp_valid !== 4'b0001) $display("FAIL wrap_rsp2_valid got %b want 0001", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_c !== 32'hFFFF_0001) $display("FAIL wrap_rsp2_c got %h want ffff0001", bus.rsp_c); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL wrap_busy_off got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    CplxQ15 ta [8];
    CplxQ15 tb [8];
    CplxQ15 exp_c;
    ta[0] = 32'h1234_5678; tb[0] = 32'h7FFF_0001;
    ta[1] = 32'hC000_4000; tb[1] = 32'h2000_E000;
    ta[2] = 32'h7FFF_8000; tb[2] = 32'h0100_FF00;
    ta[3] = 32'hA5A5_5A5A; tb[3] = 32'h3C3C_C3C3;
    ta[4] = 32'h0001_FFFF; tb[4] = 32'h8000_8000;
    ta[5] = 32'h6000_9000; tb[5] = 32'h6000_7000;
    ta[6] = 32'hDEAD_BEEF; tb[6] = 32'h1357_9BDF;
    ta[7] = 32'h4000_C000; tb[7] = 32'h4000_4000;
    for (int j = 0; j < NREQ; j++) begin
      bus.req_a[j] = ta[j];
      bus.req_b[j] = tb[j];
    end
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 11; k++) begin
      if (k == 8) bus.req_valid = '0;
      #1;
      if (k < 8) begin
        n_total++; if (bus.req_ready !== 4'(1 << (k % 4))) $display("FAIL rr_ready[%0d] got %b want %b", k, bus.req_ready, 4'(1 << (k % 4))); else n_pass++;
      end
      if (k >= 3) begin
        exp_c = mulCplxQ15(ta[k-3], tb[k-3]);
        n_total++; if (bus.rsp_valid !== 4'(1 << ((k - 3) % 4))) $display("FAIL rr_rsp_valid[%0d] got %b want %b", k - 3, bus.rsp_valid, 4'(1 << ((k - 3) % 4))); else n_pass++;
        n_total++; if (bus.rsp_c !== exp_c) $display("FAIL rr_rsp_c[%0d] got %h want %h", k - 3, bus.rsp_c, exp_c); else n_pass++;
      end else begin
        n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL rr_rsp_idle[%0d] got %b want 0000", k, bus.rsp_valid); else n_pass++;
      end
      tick();
      if (k < 4) begin
        bus.req_a[k] = ta[k+4];
        bus.req_b[k] = tb[k+4];
      end
    end
    n_total++; if (ops_cnt !== 32'd8) $display("FAIL rr_ops got %0d want 8", ops_cnt); else n_pass++;
  endtask

  task automatic test_fairness();
    bus.req_valid = 4'b0100;
    #1;
    n_total++; if (bus.req_ready !== 4'b0100) $display("FAIL fair_ready2 got %b want 0100", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 4'b1010;
    #1;
    n_total++; if (bus.req_ready !== 4'b1000) $display("FAIL fair_ready3 got %b want 1000", bus.req_ready); else n_pass++;
    tick();
    #1;
    n_total++; if (bus.req_ready !== 4'b0010) $display("FAIL fair_ready1 got %b want 0010", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    n_total++; if (bus.rsp_valid !== 4'b0100) $display("FAIL fair_rsp2 got %b want 0100", bus.rsp_valid); else n_pass++;
    tick();
    n_total++; if (bus.rsp_valid !== 4'b1000) $display("FAIL fair_rsp3 got %b want 1000", bus.rsp_valid); else n_pass++;
    tick();
    n_total++; if (bus.rsp_valid !== 4'b0010) $display("FAIL fair_rsp1 got %b want 0010", bus.rsp_valid); else n_pass++;
    tick();
    n_total++; if (ops_cnt !== 32'd11) $display("FAIL fair_ops got %0d want 11", ops_cnt); else n_pass++;
  endtask

  task automatic test_hold();
    bus.req_valid = 4'b1111;
    #1;
    n_total++; if (bus.req_ready !== 4'b0100) $display("FAIL hold_pre_ready0 got %b want 0100", bus.req_ready); else n_pass++;
    tick();
    #1;
    n_total++; if (bus.req_ready !== 4'b1000) $display("FAIL hold_pre_ready1 got %b want 1000", bus.req_ready); else n_pass++;
    tick();
    hold = 1'b1;
    #1;
    n_total++; if (bus.req_ready !== 4'b0000) $display("FAIL hold_ready_now got %b want 0000", bus.req_ready); else n_pass++;
    tick();
    n_total++; if (bus.rsp_valid !== 4'b0100) $display("FAIL hold_rsp2 got %b want 0100", bus.rsp_valid); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL hold_busy_a got %b want 1", busy); else n_pass++;
    tick();
    n_total++; if (bus.rsp_valid !== 4'b1000) $display("FAIL hold_rsp3 got %b want 1000", bus.rsp_valid); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL hold_busy_b got %b want 1", busy); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL hold_busy_fall got %b want 0", busy); else n_pass++;
    n_total++; if (bus.req_ready !== 4'b0000) $display("FAIL hold_ready_late got %b want 0000", bus.req_ready); else n_pass++;
    n_total++; if (ops_cnt !== 32'd13) $display("FAIL hold_ops got %0d want 13", ops_cnt); else n_pass++;
    hold = 1'b0;
    #1;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL hold_release_ready got %b want 0001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    n_total++; if (bus.rsp_valid !== 4'b0001) $display("FAIL hold_release_rsp got %b want 0001", bus.rsp_valid); else n_pass++;
    tick();
  endtask

  task automatic test_reset_flush();
    bus.req_valid = 4'b1111;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_total++; if (bus.req_ready !== 4'b0000) $display("FAIL flush_ready_in_rst got %b want 0000", bus.req_ready); else n_pass++;
    tick();
    rst           = 1'b0;
    bus.req_valid = '0;
    n_total++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else n_pass++;
    n_total++; if (ops_cnt !== 32'd0) $display("FAIL flush_ops got %0d want 0", ops_cnt); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL flush_rsp[%0d] got %b want 0000", k, bus.rsp_valid); else n_pass++;
      tick();
    end
    bus.req_valid = 4'b0011;
    #1;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL flush_ptr_ready0 got %b want 0001", bus.req_ready); else n_pass++;
    tick();
    #1;
    n_total++; if (bus.req_ready !== 4'b0010) $display("FAIL flush_ptr_ready1 got %b want 0010", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    n_total++; if (ops_cnt !== 32'd2) $display("FAIL flush_ops_after got %0d want 2", ops_cnt); else n_pass++;
    tick();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    do_reset();
    test_wrap();
    do_reset();
    test_round_robin();
    test_fairness();
    test_hold();
    test_reset_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
